// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with run/halt control, relative jumps and call/return stack
//
// Purpose: holds and advances the fetch PC. Branch and call offsets come from an
// external relative-jump lookup table indexed by jmp_idx; returns pop a shallow
// hardware stack of return addresses.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             pulse: (re)start execution from START_PC
//   stall             hold pc, stack and stack_err for this cycle
//   halt              end of program, enter DONE
//   branch/call/ret   relative branch, relative call, return
//   jmp_idx           lookup-table index for branch/call offset
//   lut_addr          index to lookup table (combinational copy of jmp_idx)
//   lut_target        signed D-bit offset from lookup table
//   pc                current program counter
//   busy, done        RUN / DONE state decode
//   stack_err         sticky stack overflow/underflow flag
module pc_sequencer #(
  parameter int D           = 12,
  parameter int START_PC    = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt,
  input  logic         branch,
  input  logic         call,
  input  logic         ret,
  input  logic [5:0]   jmp_idx,
  output logic [5:0]   lut_addr,
  input  logic [D-1:0] lut_target,
  output logic [D-1:0] pc,
  output logic         busy,
  output logic         done,
  output logic         stack_err
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [D-1:0]  PC_INIT = D'(START_PC);
  localparam logic [D-1:0]  PC_ONE  = D'(1);
  localparam logic [DW-1:0] FULL    = DW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [D-1:0]  pc_n;
  logic [DW-1:0] depth, depth_n;
  logic          err_n;
  logic          push;
  logic [D-1:0]  stack_mem [STACK_DEPTH];

  logic [D-1:0]  pc_inc;
  logic [D-1:0]  pc_rel;
  logic [AW-1:0] top_idx;

  assign lut_addr = jmp_idx;
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);

  // Unsigned add of the two's-complement offset gives the correct truncated sum.
  assign pc_inc  = pc + PC_ONE;
  assign pc_rel  = pc + lut_target;
  // At depth==STACK_DEPTH the low bits wrap to 0, so subtracting 1 still lands on the last entry.
  assign top_idx = depth[AW-1:0] - 1'b1;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    depth_n = depth;
    err_n   = stack_err;
    push    = 1'b0;
    case (state)
      S_IDLE: begin
        pc_n = PC_INIT;
        if (start) state_n = S_RUN;
      end
      S_RUN: begin
        if (halt) begin
          state_n = S_DONE;
        end else if (stall) begin
          pc_n = pc;
        end else if (ret) begin
          if (depth != '0) begin
            pc_n    = stack_mem[top_idx];
            depth_n = depth - 1'b1;
          end else begin
            err_n = 1'b1;
            pc_n  = pc_inc;
          end
        end else if (call) begin
          if (depth != FULL) begin
            push    = 1'b1;
            depth_n = depth + 1'b1;
            pc_n    = pc_rel;
          end else begin
            err_n = 1'b1;
            pc_n  = pc_inc;
          end
        end else if (branch) begin
          pc_n = pc_rel;
        end else begin
          pc_n = pc_inc;
        end
      end
      S_DONE: begin
        if (start) begin
          state_n = S_RUN;
          pc_n    = PC_INIT;
          depth_n = '0;
          err_n   = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
        pc_n    = PC_INIT;
        depth_n = '0;
        err_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= PC_INIT;
      depth     <= '0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      depth     <= depth_n;
      stack_err <= err_n;
    end
  end

  // Entries are meaningful only below depth, so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (push && !reset) stack_mem[depth[AW-1:0]] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  localparam int D = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic         halt = 1'b0;
  logic         branch = 1'b0;
  logic         call = 1'b0;
  logic         ret = 1'b0;
  logic [5:0]   jmp_idx = '0;
  logic [5:0]   lut_addr;
  logic [D-1:0] lut_target = '0;
  logic [D-1:0] pc;
  logic         busy;
  logic         done;
  logic         stack_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        tag;
    logic [D-1:0] pc;
    logic         busy;
    logic         done;
    logic         err;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer #(.D(D), .START_PC(0), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .halt       (halt),
    .branch     (branch),
    .call       (call),
    .ret        (ret),
    .jmp_idx    (jmp_idx),
    .lut_addr   (lut_addr),
    .lut_target (lut_target),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: one expectation per clock edge, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".pc"},   32'(pc),        32'(e.pc));
      check({e.tag, ".busy"}, 32'(busy),      32'(e.busy));
      check({e.tag, ".done"}, 32'(done),      32'(e.done));
      check({e.tag, ".err"},  32'(stack_err), 32'(e.err));
    end
  end

  // Drive one cycle of stimulus and queue the state expected after the next edge.
  task automatic cyc(input string tag,
                     input logic rs, input logic st, input logic sl, input logic hl,
                     input logic br, input logic ca, input logic rt,
                     input logic [D-1:0] tgt,
                     input logic [D-1:0] epc, input logic eb, input logic ed, input logic ee);
    exp_t e;
    reset      = rs;
    start      = st;
    stall      = sl;
    halt       = hl;
    branch     = br;
    call       = ca;
    ret        = rt;
    lut_target = tgt;
    jmp_idx    = 6'($urandom_range(0, 63));
    e.tag  = tag;
    e.pc   = epc;
    e.busy = eb;
    e.done = ed;
    e.err  = ee;
    exp_q.push_back(e);
    #1;
    check({tag, ".lut_addr"}, 32'(lut_addr), 32'(jmp_idx));
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1;
    //  tag            rs st sl hl br ca rt tgt      pc     b  d  e
    cyc("reset",       1, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0);
    cyc("idle_ign",    0, 0, 0, 0, 1, 1, 0, 12'h005, 12'h000, 0, 0, 0);
    cyc("start",       0, 1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0);
    cyc("seq1",        0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h001, 1, 0, 0);
    cyc("seq2",        0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h002, 1, 0, 0);
    cyc("seq3",        0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h003, 1, 0, 0);
    cyc("seq4",        0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h004, 1, 0, 0);
    cyc("br_neg",      0, 0, 0, 0, 1, 0, 0, 12'hFFB, 12'hFFF, 1, 0, 0);
    cyc("wrap",        0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0);
    cyc("start_run",   0, 1, 0, 0, 0, 0, 0, 12'h000, 12'h001, 1, 0, 0);
    cyc("br_to_10",    0, 0, 0, 0, 1, 0, 0, 12'h00F, 12'h010, 1, 0, 0);
    cyc("call20",      0, 0, 0, 0, 0, 1, 0, 12'd20,  12'h024, 1, 0, 0);
    cyc("after_call",  0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h025, 1, 0, 0);
    cyc("ret_11",      0, 0, 0, 0, 0, 0, 1, 12'h000, 12'h011, 1, 0, 0);
    cyc("halt_call",   0, 0, 0, 1, 0, 1, 0, 12'h004, 12'h011, 0, 1, 0);
    cyc("done_ign",    0, 0, 0, 0, 1, 0, 1, 12'h005, 12'h011, 0, 1, 0);
    cyc("restart1",    0, 1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0);
    cyc("call_a",      0, 0, 0, 0, 0, 1, 0, 12'h002, 12'h002, 1, 0, 0);
    cyc("call_b",      0, 0, 0, 0, 0, 1, 0, 12'h002, 12'h004, 1, 0, 0);
    cyc("call_c",      0, 0, 0, 0, 0, 1, 0, 12'h002, 12'h006, 1, 0, 0);
    cyc("call_d",      0, 0, 0, 0, 0, 1, 0, 12'h002, 12'h008, 1, 0, 0);
    cyc("call_ovf",    0, 0, 0, 0, 0, 1, 0, 12'h002, 12'h009, 1, 0, 1);
    cyc("stall_call",  0, 0, 1, 0, 0, 1, 0, 12'h002, 12'h009, 1, 0, 1);
    cyc("ret_7",       0, 0, 0, 0, 0, 0, 1, 12'h000, 12'h007, 1, 0, 1);
    cyc("ret_5",       0, 0, 0, 0, 0, 0, 1, 12'h000, 12'h005, 1, 0, 1);
    cyc("ret_3",       0, 0, 0, 0, 0, 0, 1, 12'h000, 12'h003, 1, 0, 1);
    cyc("ret_1",       0, 0, 0, 0, 0, 0, 1, 12'h000, 12'h001, 1, 0, 1);
    cyc("halt2",       0, 0, 0, 1, 0, 0, 0, 12'h000, 12'h001, 0, 1, 1);
    cyc("restart2",    0, 1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0);
    cyc("ret_udf",     0, 0, 0, 0, 0, 0, 1, 12'h000, 12'h001, 1, 0, 1);
    cyc("stall_br",    0, 0, 1, 0, 1, 0, 0, 12'h007, 12'h001, 1, 0, 1);
    cyc("call_over_br",0, 0, 0, 0, 1, 1, 0, 12'h010, 12'h011, 1, 0, 1);
    cyc("ret_over_all",0, 0, 0, 0, 1, 1, 1, 12'h030, 12'h002, 1, 0, 1);
    cyc("br_zero",     0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h002, 1, 0, 1);
    cyc("br_to_a3",    0, 0, 0, 0, 1, 0, 0, 12'h0A1, 12'h0A3, 1, 0, 1);
    cyc("reset_mid",   1, 0, 0, 0, 0, 1, 0, 12'h010, 12'h000, 0, 0, 0);
    cyc("idle_after",  0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0);
    cyc("start3",      0, 1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0);
    cyc("ret_clr",     0, 0, 0, 0, 0, 0, 1, 12'h000, 12'h001, 1, 0, 1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the 9-bit processor fetch path; the consuming end of the relative-jump lookup table.
- Presents a 6-bit jump index to the lookup table and takes back a signed D-bit offset.
- Holds and advances the PC with run/halt control, stalls, relative branches and a shallow call/return stack.
- Its pc output drives instruction-memory address; done signals program completion to the test harness.

Parameters:
D, 12, PC width in bits; all PC arithmetic is modulo 2**D.
START_PC, 0, PC value loaded at reset and on every (re)start.
STACK_DEPTH, 4, number of return-address entries (power of 2, >=2).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse: begin execution from START_PC
stall  input  1  hold PC and stack this cycle
halt  input  1  end of program; enter DONE
branch  input  1  resolved-taken relative branch: PC += offset
call  input  1  relative call: push PC+1, PC += offset
ret  input  1  return: PC <= popped address
jmp_idx  input  6  lookup index for branch/call offset
lut_addr  output  6  index to lookup table, combinationally equal to jmp_idx
lut_target  input  D  signed offset returned combinationally by the lookup table
pc  output  D  current program counter
busy  output  1  high in RUN state
done  output  1  high in DONE state
stack_err  output  1  sticky overflow/underflow flag

Behaviour:
- States: IDLE, RUN, DONE (registered). Reset -> IDLE, pc=START_PC, stack depth=0, stack_err=0, busy=0, done=0.
- busy and done decode directly from the state; no extra latency.
- IDLE:
  - pc held at START_PC; all control inputs except start ignored.
  - start -> RUN next cycle; pc stays START_PC, so the first fetch is START_PC.
- RUN: one action per cycle, evaluated in this priority order:
  1. halt: -> DONE; pc holds.
  2. stall: pc, stack and stack_err hold.
  3. ret:
     - depth>0: pc <= top entry, depth-1.
     - depth==0: stack_err<=1, pc <= pc+1.
  4. call:
     - depth<STACK_DEPTH: push pc+1, pc <= pc+lut_target.
     - full: stack_err<=1, no push, pc <= pc+1 (call suppressed).
  5. branch: pc <= pc+lut_target.
  6. otherwise: pc <= pc+1.
- Arithmetic rules:
  - lut_target is two's-complement; the sum is truncated to D bits.
  - Wrap-around is silent: 0xFFF+1=0x000; 0x002+(-5)=0xFFD.
  - Offset 0 is legal and holds the PC.
- Pushed return address is (pc+1) mod 2**D.
- Simultaneous ret/call/branch: only the highest-priority action occurs; the others are dropped, not queued.
- DONE:
  - pc, stack and stack_err frozen; done=1.
  - start -> RUN next cycle with pc=START_PC, depth=0, stack_err=0.
  - All other inputs ignored.
- start while RUN: ignored.
- Reset asserted in any state, including mid-stall or mid-call: next cycle all values equal the reset values; stack contents are don't-care once depth=0.
- No combinational path from any input to pc, busy, done or stack_err.

Test Plan:
- Reset, pulse start, run 5 idle cycles -> pc sequence 0,0,1,2,3,4; busy=1, done=0.
- At pc=4, branch=1 with lut_target=0xFFB (-5) -> next pc=0xFFF; following cycle pc=0x000 (wrap).
- At pc=0x010, call with lut_target=20 -> pc=0x024; ret two cycles later (pc=0x025) -> pc=0x011; depth back to 0.
- 5 consecutive calls (offset +2) from pc=0 -> first 4 push 1,3,5,7 and jump; 5th sets stack_err=1 and pc advances by 1 only; 4 rets pop in order 7,5,3,1.
- ret at depth 0 -> stack_err=1, pc+1; stall with branch asserted -> pc unchanged; halt with call asserted -> DONE, pc unchanged, done=1.
- From DONE, pulse start -> RUN, pc=0, stack_err=0; reset asserted mid-RUN at pc=0x0A3 -> next cycle IDLE, pc=0, busy=0.
